// File: rtl/square_seq_pkg.sv
// ============================================================================
// Module      : square_seq_pkg
// Description : Shared limb width, FSM state type and product-count helper for
//               the sequential limb squarer. SQUARE_SEQ_SYMMETRY_EN selects the
//               half-triangle product schedule.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package square_seq_pkg;

  localparam int LIMB_W = 17;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Number of MUL cycles one squaring takes for n limbs.
  function automatic int num_products(input int n);
`ifdef SQUARE_SEQ_SYMMETRY_EN
    return n * (n + 1) / 2;
`else
    return n * n;
`endif
  endfunction

endpackage

`default_nettype wire

// File: rtl/square_seq_if.sv
// ============================================================================
// Module      : square_seq_if
// Description : Start/operand request and busy/done/result response bundle of
//               square_seq.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface square_seq_if #(
  parameter int NUM_LIMBS = 3
);

  localparam int OP_W = NUM_LIMBS * square_seq_pkg::LIMB_W;

  logic              start;
  logic [OP_W-1:0]   x;
  logic              busy;
  logic              done;
  logic [2*OP_W-1:0] sq;

  modport master (
    output start,
    output x,
    input  busy,
    input  done,
    input  sq
  );

  modport slave (
    input  start,
    input  x,
    output busy,
    output done,
    output sq
  );

endinterface

`default_nettype wire

// File: rtl/mult_17x17.sv
// ============================================================================
// Module      : mult_17x17
// Description : Combinational unsigned 17x17 -> 34-bit multiplier.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mult_17x17 (
  input  logic [16:0] x,
  input  logic [16:0] y,
  output logic [33:0] p
);

  assign p = 34'(x) * 34'(y);

endmodule

`default_nettype wire

// File: rtl/square_seq.sv
// ============================================================================
// Module      : square_seq
// Description : Exact squarer issuing one limb product per cycle into a
//               full-width accumulator. SQUARE_SEQ_SYMMETRY_EN doubles cross
//               products and skips the mirrored half.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module square_seq #(
  parameter int NUM_LIMBS = 3,
  parameter int LIMB_W    = 17
) (
  input  logic        clk,
  input  logic        reset,
  square_seq_if.slave bus
);

  import square_seq_pkg::*;

  localparam int OP_W  = NUM_LIMBS * LIMB_W;
  localparam int ACC_W = 2 * OP_W;
  localparam int IDX_W = $clog2(NUM_LIMBS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_LIMBS - 1);

  state_t             r_state;
  state_t             w_state_nxt;
  logic [IDX_W-1:0]   r_i;
  logic [IDX_W-1:0]   r_j;
  logic [IDX_W-1:0]   w_i_nxt;
  logic [IDX_W-1:0]   w_j_nxt;
  logic [OP_W-1:0]    r_x;
  logic [OP_W-1:0]    w_x_nxt;
  logic [ACC_W-1:0]   r_acc;
  logic [ACC_W-1:0]   w_acc_nxt;
  logic [LIMB_W-1:0]  w_a;
  logic [LIMB_W-1:0]  w_b;
  logic [2*LIMB_W-1:0] w_p;
  logic [ACC_W-1:0]   w_term;
  int unsigned        w_shift;

  assign w_a     = r_x[LIMB_W*int'(r_i) +: LIMB_W];
  assign w_b     = r_x[LIMB_W*int'(r_j) +: LIMB_W];
  assign w_shift = LIMB_W * (int'(r_i) + int'(r_j));

  mult_17x17 u_mult (
    .x (w_a),
    .y (w_b),
    .p (w_p)
  );

`ifdef SQUARE_SEQ_SYMMETRY_EN
  // Off-diagonal products stand in for their mirrored twin, so count twice.
  logic w_dbl;
  assign w_dbl  = (r_i != r_j);
  assign w_term = (ACC_W'(w_p) << w_shift) << w_dbl;
`else
  assign w_term = ACC_W'(w_p) << w_shift;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_i     <= '0;
      r_j     <= '0;
      r_x     <= '0;
      r_acc   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_i     <= w_i_nxt;
      r_j     <= w_j_nxt;
      r_x     <= w_x_nxt;
      r_acc   <= w_acc_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_i_nxt     = r_i;
    w_j_nxt     = r_j;
    w_x_nxt     = r_x;
    w_acc_nxt   = r_acc;
    case (r_state)
      IDLE, DONE: begin
        if (bus.start) begin
          w_state_nxt = MUL;
          w_x_nxt     = bus.x;
          w_acc_nxt   = '0;
          w_i_nxt     = '0;
          w_j_nxt     = '0;
        end else begin
          w_state_nxt = IDLE;
        end
      end
      MUL: begin
        w_acc_nxt = r_acc + w_term;
        if (r_j == LAST_IDX) begin
          if (r_i == LAST_IDX) begin
            w_state_nxt = DONE;
          end else begin
            w_i_nxt = r_i + IDX_W'(1);
`ifdef SQUARE_SEQ_SYMMETRY_EN
            w_j_nxt = r_i + IDX_W'(1);
`else
            w_j_nxt = '0;
`endif
          end
        end else begin
          w_j_nxt = r_j + IDX_W'(1);
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  assign bus.busy = (r_state == MUL);
  assign bus.done = (r_state == DONE);
  assign bus.sq   = r_acc;

endmodule

`default_nettype wire

// File: tb/tb_square_seq.sv
// ============================================================================
// Module      : tb_square_seq
// Description : Self-checking bench for square_seq: directed table and corner
//               sequences at 3 limbs, random scoreboards at 2, 3 and 6 limbs.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_square_seq;

`ifdef SQUARE_SEQ_SYMMETRY_EN
  localparam int P3 = 6;
`else
  localparam int P3 = 9;
`endif
  localparam int LAT3  = P3 + 1;
  localparam int NRAND = 1000;

  logic clk = 1'b0;
  logic rst;
  logic rst_d;
  int   checks   = 0;
  int   failures = 0;
  bit   rnd_done[3];

  always #5 clk = ~clk;

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic logic [101:0] ref3(input logic [50:0] v);
    logic [101:0] e;
    e = {51'd0, v};
    return e * e;
  endfunction

  // ---------------- directed instance, 3 limbs ----------------
  square_seq_if #(.NUM_LIMBS(3)) dbus ();
  square_seq #(.NUM_LIMBS(3)) u_dir (
    .clk   (clk),
    .reset (rst_d),
    .bus   (dbus)
  );

  logic [101:0] dq[$];
  logic [101:0] dexp;

  always @(negedge clk) begin
    if (!rst_d && dbus.done) begin
      checks++;
      if (dq.size() == 0) begin
        failures++;
        $display("FAIL dir_sq: done with nothing pending, got %h", dbus.sq);
      end else begin
        dexp = dq.pop_front();
        if (dbus.sq !== dexp) begin
          failures++;
          $display("FAIL dir_sq: got %h expected %h", dbus.sq, dexp);
        end
      end
    end
  end

  // One operation; optionally re-pulses start with another operand in MUL cycle 'poke'.
  task automatic run_op(input logic [50:0] xv, input logic [101:0] ev, input string nm, input int poke);
    int first_done;
    int ndone;
    int nbusy;
    @(negedge clk);
    dbus.start = 1'b1;
    dbus.x     = xv;
    dq.push_back(ev);
    @(negedge clk);
    dbus.start = 1'b0;
    first_done = 0;
    ndone      = 0;
    nbusy      = 0;
    for (int k = 1; k <= LAT3 + 2; k++) begin
      if (dbus.busy) nbusy++;
      if (dbus.done) begin
        ndone++;
        if (first_done == 0) first_done = k;
      end
      dbus.x     = 51'({$urandom(), $urandom()});
      dbus.start = (k == poke);
      @(negedge clk);
    end
    dbus.start = 1'b0;
    chk({nm, " done_cycle"}, first_done, LAT3);
    chk({nm, " busy_cycles"}, nbusy, P3);
    chk({nm, " done_count"}, ndone, 1);
    checks++;
    if (dbus.sq !== ev) begin
      failures++;
      $display("FAIL %s sq_hold: got %h expected %h", nm, dbus.sq, ev);
    end
  endtask

  typedef struct {
    logic [50:0]  x;
    logic [101:0] sq;
  } vec_t;

  vec_t tv[7];

  // ---------------- random scoreboards at 2, 3 and 6 limbs ----------------
  for (genvar g = 0; g < 3; g++) begin : g_rnd
    localparam int NL     = (g == 0) ? 2 : (g == 1) ? 3 : 6;
    localparam int W      = NL * 17;
    localparam int BUDGET = NRAND * (NL * NL + 2) + 200;

    square_seq_if #(.NUM_LIMBS(NL)) bus ();
    square_seq #(.NUM_LIMBS(NL)) u_dut (
      .clk   (clk),
      .reset (rst),
      .bus   (bus)
    );

    logic [2*W-1:0] q[$];
    logic [2*W-1:0] mexp;

    always @(negedge clk) begin
      if (!rst && bus.done) begin
        checks++;
        if (q.size() == 0) begin
          failures++;
          $display("FAIL rnd%0d_sq: done with nothing pending, got %h", NL, bus.sq);
        end else begin
          mexp = q.pop_front();
          if (bus.sq !== mexp) begin
            failures++;
            $display("FAIL rnd%0d_sq: got %h expected %h", NL, bus.sq, mexp);
          end
        end
      end
    end

    initial begin : drv
      logic [W-1:0]   xv;
      logic [2*W-1:0] xe;
      int issued;
      int cyc;
      bus.start = 1'b0;
      bus.x     = '0;
      @(negedge clk);
      while (rst) @(negedge clk);
      issued = 0;
      cyc    = 0;
      // start stays high; an operand counts only when the DUT can accept it
      while (issued < NRAND && cyc < BUDGET) begin
        for (int b = 0; b < W; b++) xv[b] = 1'($urandom_range(0, 1));
        if ((issued % 16) == 5) xv = '1;
        bus.x     = xv;
        bus.start = 1'b1;
        if (!bus.busy) begin
          xe = '0;
          xe[W-1:0] = xv;
          q.push_back(xe * xe);
          issued++;
        end
        @(negedge clk);
        cyc++;
      end
      bus.start = 1'b0;
      cyc = 0;
      while (q.size() != 0 && cyc < 200) begin
        @(negedge clk);
        cyc++;
      end
      checks++;
      if (issued != NRAND || q.size() != 0) begin
        failures++;
        $display("FAIL rnd%0d_drain: issued %0d of %0d, %0d results outstanding", NL, issued, NRAND, q.size());
      end
      rnd_done[g] = 1'b1;
    end
  end

  // ---------------- directed sequences ----------------
  initial begin
    int n;
    int nd;
    int last;
    int cyc;
    logic [50:0] bx;

    rst        = 1'b1;
    rst_d      = 1'b1;
    dbus.start = 1'b0;
    dbus.x     = '0;

    tv[0].x = 51'd0;                 tv[0].sq = 102'd0;
    tv[1].x = {51{1'b1}};            tv[1].sq = (102'd0 - (102'd1 << 52)) + 102'd1;
    tv[2].x = 51'd1 << 17;           tv[2].sq = 102'd1 << 34;
    tv[3].x = 51'h1_0000_0000_0001;  tv[3].sq = ref3(51'h1_0000_0000_0001);
    tv[4].x = 51'd1;                 tv[4].sq = 102'd1;
    tv[5].x = 51'h1FFFF;             tv[5].sq = (102'd1 << 34) - (102'd1 << 18) + 102'd1;
    tv[6].x = 51'd1 << 34;           tv[6].sq = 102'd1 << 68;

    repeat (3) @(negedge clk);
    chk("reset busy", dbus.busy, 0);
    chk("reset done", dbus.done, 0);
    chk("reset sq_zero", (dbus.sq == '0), 1);
    rst   = 1'b0;
    rst_d = 1'b0;

    for (int t = 0; t < 7; t++) run_op(tv[t].x, tv[t].sq, $sformatf("vec%0d", t), 0);

    // start re-pulsed in MUL with a different operand must be ignored
    run_op(51'h2_AAAA_1234_5678, ref3(51'h2_AAAA_1234_5678), "ignored_start", 3);

    // reset in the third MUL cycle, together with a start that must be ignored
    @(negedge clk);
    dbus.start = 1'b1;
    dbus.x     = 51'h5_5555_5555_5555;
    @(negedge clk);
    dbus.start = 1'b0;
    repeat (2) @(negedge clk);
    chk("rstmid busy_before", dbus.busy, 1);
    rst_d      = 1'b1;
    dbus.start = 1'b1;
    dbus.x     = 51'h123;
    @(negedge clk);
    chk("rstmid busy", dbus.busy, 0);
    chk("rstmid done", dbus.done, 0);
    chk("rstmid sq_zero", (dbus.sq == '0), 1);
    rst_d      = 1'b0;
    dbus.start = 1'b0;
    @(negedge clk);
    chk("rst_start ignored", dbus.busy, 0);
    run_op(51'h7_0F0F_F0F0_1357, ref3(51'h7_0F0F_F0F0_1357), "after_reset", 0);

    // start held high: back-to-back results, one done each, no idle gap
    n    = 0;
    nd   = 0;
    last = 0;
    cyc  = 0;
    while ((n < 4 || nd < 4) && cyc < 200) begin
      @(negedge clk);
      cyc++;
      if (dbus.done) begin
        if (nd > 0) chk("b2b done_spacing", cyc - last, LAT3);
        last = cyc;
        nd++;
      end
      if (n < 4) begin
        bx = 51'({$urandom(), $urandom()});
        dbus.start = 1'b1;
        dbus.x     = bx;
        if (!dbus.busy) begin
          dq.push_back(ref3(bx));
          n++;
        end
      end else begin
        dbus.start = 1'b0;
      end
    end
    dbus.start = 1'b0;
    chk("b2b done_count", nd, 4);

    cyc = 0;
    while (!(rnd_done[0] && rnd_done[1] && rnd_done[2]) && cyc < 90000) begin
      @(negedge clk);
      cyc++;
    end
    chk("random runs finished", (rnd_done[0] && rnd_done[1] && rnd_done[2]), 1);
    chk("dir scoreboard empty", dq.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
